// File: rtl/rc4_prga_engine.sv
// RC4 keystream (PRGA) engine: decrypts ciphertext ROM into plaintext RAM using a KSA-initialised S RAM.
// Optional CHAR_FILTER_EN: abort on the first byte outside [CHAR_LO, CHAR_HI] that is not CHAR_SP.
module rc4_prga_engine #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MSG_MAX = 32,
    parameter int unsigned MSG_AW  = 5,
    parameter int unsigned DROP_N  = 0,
    parameter int unsigned CHAR_LO = 97,
    parameter int unsigned CHAR_HI = 122,
    parameter int unsigned CHAR_SP = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MSG_AW:0]   msg_len,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] s_din,
    output logic              s_wren,
    input  logic [ADDR_W-1:0] s_dout,
    output logic [MSG_AW-1:0] k_addr,
    input  logic [7:0]        k_dout,
    output logic [MSG_AW-1:0] a_addr,
    output logic [7:0]        a_din,
    output logic              a_wren,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [MSG_AW-1:0] fail_index
);
    localparam int unsigned LEN_W  = MSG_AW + 1;
    localparam int unsigned DROP_W = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, INC_I, RD_SI, RD_SJ, WR_SJ, RD_KS, OUT, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] si;
    logic [ADDR_W-1:0] sj;
    logic [MSG_AW-1:0] k;
    logic [LEN_W-1:0]  len;
    logic [DROP_W-1:0] drop_cnt;
    logic [LEN_W-1:0]  len_clamped;
    logic [7:0]        pt_byte;
    logic              last_byte;
    logic              reject;

    assign len_clamped = (msg_len > LEN_W'(MSG_MAX)) ? LEN_W'(MSG_MAX) : msg_len;
    assign pt_byte     = 8'(s_dout) ^ k_dout;
    assign last_byte   = (LEN_W'(k) == (len - LEN_W'(1)));

`ifdef CHAR_FILTER_EN
    assign reject = ((pt_byte < 8'(CHAR_LO)) || (pt_byte > 8'(CHAR_HI))) && (pt_byte != 8'(CHAR_SP));
`else
    logic unused_filter_cfg;
    assign unused_filter_cfg = ^{8'(CHAR_LO), 8'(CHAR_HI), 8'(CHAR_SP)};
    assign reject            = 1'b0;
`endif

    // S RAM reads return data in the state after the address register is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            si         <= '0;
            sj         <= '0;
            k          <= '0;
            len        <= '0;
            drop_cnt   <= '0;
            s_addr     <= '0;
            s_din      <= '0;
            s_wren     <= 1'b0;
            k_addr     <= '0;
            a_addr     <= '0;
            a_din      <= '0;
            a_wren     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            fail_index <= '0;
        end else begin
            s_wren <= 1'b0;
            a_wren <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len        <= len_clamped;
                        busy       <= 1'b1;
                        success    <= 1'b0;
                        fail_index <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    i        <= '0;
                    j        <= '0;
                    k        <= '0;
                    drop_cnt <= DROP_W'(DROP_N);
                    if ((len == '0) && (DROP_N == 0)) begin
                        success <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= INC_I;
                    end
                end
                INC_I: begin
                    i      <= i + ADDR_W'(1);
                    s_addr <= i + ADDR_W'(1);
                    state  <= RD_SI;
                end
                RD_SI: begin
                    si     <= s_dout;
                    j      <= j + s_dout;
                    s_addr <= j + s_dout;
                    state  <= RD_SJ;
                end
                RD_SJ: begin
                    sj     <= s_dout;
                    s_addr <= i;
                    s_din  <= s_dout;
                    s_wren <= 1'b1;
                    state  <= WR_SJ;
                end
                WR_SJ: begin
                    s_addr <= j;
                    s_din  <= si;
                    s_wren <= 1'b1;
                    state  <= RD_KS;
                end
                RD_KS: begin
                    s_addr <= si + sj;
                    k_addr <= k;
                    state  <= OUT;
                end
                OUT: begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - DROP_W'(1);
                        // A zero-length run with discard ends once the last dropped byte is consumed.
                        if ((drop_cnt == DROP_W'(1)) && (len == '0)) begin
                            success <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= INC_I;
                        end
                    end else begin
                        a_addr <= k;
                        a_din  <= pt_byte;
                        a_wren <= 1'b1;
                        if (reject) begin
                            success    <= 1'b0;
                            fail_index <= k;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else if (last_byte) begin
                            success <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            k     <= k + MSG_AW'(1);
                            state <= INC_I;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Directed bench for rc4_prga_engine: S RAM preloaded with KSA("Key"), default and DROP_N=3 instances.
module tb_rc4_prga_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       prep;
    logic       start0, start1;
    logic [5:0] msg_len0, msg_len1;

    logic [7:0] s_addr0, s_din0, s_dout0, s_addr1, s_din1, s_dout1;
    logic       s_wren0, s_wren1;
    logic [4:0] k_addr0, a_addr0, fail_index0, k_addr1, a_addr1, fail_index1;
    logic [7:0] k_dout0, a_din0, k_dout1, a_din1;
    logic       a_wren0, busy0, done0, success0;
    logic       a_wren1, busy1, done1, success1;

    rc4_prga_engine u_dut (
        .clk(clk), .reset(reset), .start(start0), .msg_len(msg_len0),
        .s_addr(s_addr0), .s_din(s_din0), .s_wren(s_wren0), .s_dout(s_dout0),
        .k_addr(k_addr0), .k_dout(k_dout0),
        .a_addr(a_addr0), .a_din(a_din0), .a_wren(a_wren0),
        .busy(busy0), .done(done0), .success(success0), .fail_index(fail_index0)
    );

    rc4_prga_engine #(.DROP_N(3)) u_drop (
        .clk(clk), .reset(reset), .start(start1), .msg_len(msg_len1),
        .s_addr(s_addr1), .s_din(s_din1), .s_wren(s_wren1), .s_dout(s_dout1),
        .k_addr(k_addr1), .k_dout(k_dout1),
        .a_addr(a_addr1), .a_din(a_din1), .a_wren(a_wren1),
        .busy(busy1), .done(done1), .success(success1), .fail_index(fail_index1)
    );

    logic [7:0] s_init [256];
    logic [7:0] ks [64];
    logic [7:0] s_mem0 [256];
    logic [7:0] s_mem1 [256];
    logic [7:0] ct_mem0 [32];
    logic [7:0] ct_mem1 [32];
    logic [7:0] a_mem0 [32];
    logic [7:0] a_mem1 [32];
    int         a_cnt0, s_cnt0, a_cnt1, s_cnt1;
    logic [4:0] kmax0, amax0;

    // Memories whose address register is the engine's own address flop.
    assign s_dout0 = s_mem0[s_addr0];
    assign k_dout0 = ct_mem0[k_addr0];
    assign s_dout1 = s_mem1[s_addr1];
    assign k_dout1 = ct_mem1[k_addr1];

    always @(posedge clk) begin
        if (prep) begin
            s_mem0 <= s_init;
            s_mem1 <= s_init;
            a_mem0 <= '{default: 8'h00};
            a_mem1 <= '{default: 8'h00};
            a_cnt0 <= 0;
            s_cnt0 <= 0;
            a_cnt1 <= 0;
            s_cnt1 <= 0;
            kmax0  <= '0;
            amax0  <= '0;
        end else begin
            if (s_wren0) begin
                s_mem0[s_addr0] <= s_din0;
                s_cnt0          <= s_cnt0 + 1;
            end
            if (a_wren0) begin
                a_mem0[a_addr0] <= a_din0;
                a_cnt0          <= a_cnt0 + 1;
                if (a_addr0 > amax0) amax0 <= a_addr0;
            end
            if (k_addr0 > kmax0) kmax0 <= k_addr0;
            if (s_wren1) begin
                s_mem1[s_addr1] <= s_din1;
                s_cnt1          <= s_cnt1 + 1;
            end
            if (a_wren1) begin
                a_mem1[a_addr1] <= a_din1;
                a_cnt1          <= a_cnt1 + 1;
            end
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_prep();
        prep = 1'b1;
        @(posedge clk); #1;
        prep = 1'b0;
    endtask

    // Pulse start, then count cycles until done; poke re-pulses start mid-run on the default instance.
    task automatic run(input bit which, input logic [5:0] len, input bit poke, output int cycles);
        if (which) begin
            start1 = 1'b1; msg_len1 = len;
        end else begin
            start0 = 1'b1; msg_len0 = len;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        cycles = 1;
        while (!(which ? done1 : done0) && cycles < 400) begin
            if (poke && !which && cycles == 10) begin
                start0 = 1'b1; msg_len0 = '0;
            end
            @(posedge clk); #1;
            start0 = 1'b0;
            cycles++;
        end
        check(which ? "done1_seen" : "done0_seen", 32'(which ? done1 : done0), 1);
    endtask

    initial begin
        logic [7:0] t [256];
        logic [7:0] key [3];
        logic [7:0] ct_pt [9];
        logic [7:0] ii, jj, tmp;
        string      pt_str, atk_str;
        int         cyc;

        pt_str   = "Plaintext";
        atk_str  = "attack at dawn";
        ct_pt    = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        reset    = 1'b1;
        prep     = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        msg_len0 = '0;
        msg_len1 = '0;
        ct_mem0  = '{default: 8'h00};
        ct_mem1  = '{default: 8'h00};

        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        for (int n = 0; n < 256; n++) t[n] = 8'(n);
        jj = '0;
        for (int n = 0; n < 256; n++) begin
            jj = 8'(jj + t[n] + key[n % 3]);
            tmp = t[n]; t[n] = t[jj]; t[jj] = tmp;
        end
        s_init = t;
        ii = '0; jj = '0;
        for (int n = 0; n < 64; n++) begin
            ii = 8'(ii + 8'd1);
            jj = 8'(jj + t[ii]);
            tmp = t[ii]; t[ii] = t[jj]; t[jj] = tmp;
            ks[n] = t[8'(t[ii] + t[jj])];
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_success", 32'(success0), 0);
        check("rst_s_wren", 32'(s_wren0), 0);
        check("rst_a_wren", 32'(a_wren0), 0);
        check("rst_fail_index", 32'(fail_index0), 0);
        check("rst_s_addr", 32'(s_addr0), 0);
        check("rst_k_addr", 32'(k_addr0), 0);
        check("rst_a_addr", 32'(a_addr0), 0);
        check("rst_a_din", 32'(a_din0), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Known vector: key "Key", "Plaintext"
        for (int n = 0; n < 9; n++) ct_mem0[n] = ct_pt[n];
        do_prep();
        run(1'b0, 6'd9, 1'b0, cyc);
`ifdef CHAR_FILTER_EN
        check("pt_cycles", 32'(cyc), 8);
        check("pt_success", 32'(success0), 0);
        check("pt_fail_index", 32'(fail_index0), 0);
        @(posedge clk); #1;
        check("pt_byte0", 32'(a_mem0[0]), 'h50);
        check("pt_a_wren_count", 32'(a_cnt0), 1);
`else
        check("pt_cycles", 32'(cyc), 56);
        check("pt_success", 32'(success0), 1);
        check("pt_fail_index", 32'(fail_index0), 0);
        @(posedge clk); #1;
        for (int n = 0; n < 9; n++) check($sformatf("pt_byte%0d", n), 32'(a_mem0[n]), 32'(pt_str[n]));
        check("pt_a_wren_count", 32'(a_cnt0), 9);
        check("pt_s_wren_count", 32'(s_cnt0), 18);
`endif
        check("pt_busy_after", 32'(busy0), 0);

        // Lowercase/space message, with start poked mid-run and during DONE
        for (int n = 0; n < 14; n++) ct_mem0[n] = 8'(atk_str[n]) ^ ks[n];
        do_prep();
        run(1'b0, 6'd14, 1'b1, cyc);
        check("atk_cycles", 32'(cyc), 86);
        check("atk_success", 32'(success0), 1);
        check("atk_fail_index", 32'(fail_index0), 0);
        start0 = 1'b1; msg_len0 = 6'd9;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("done_start_busy", 32'(busy0), 0);
        check("done_start_done", 32'(done0), 0);
        check("success_held", 32'(success0), 1);
        for (int n = 0; n < 14; n++) check($sformatf("atk_byte%0d", n), 32'(a_mem0[n]), 32'(atk_str[n]));
        check("atk_a_wren_count", 32'(a_cnt0), 14);
        check("atk_k_max", 32'(kmax0), 13);
        check("atk_a_max", 32'(amax0), 13);

        // Zero-length message
        do_prep();
        run(1'b0, 6'd0, 1'b0, cyc);
        check("zero_cycles", 32'(cyc), 2);
        check("zero_success", 32'(success0), 1);
        @(posedge clk); #1;
        check("zero_s_wren_count", 32'(s_cnt0), 0);
        check("zero_a_wren_count", 32'(a_cnt0), 0);

        // msg_len above MSG_MAX clamps to 32
        for (int n = 0; n < 32; n++) ct_mem0[n] = 8'h61 ^ ks[n];
        do_prep();
        run(1'b0, 6'd40, 1'b0, cyc);
        check("clamp_cycles", 32'(cyc), 194);
        check("clamp_success", 32'(success0), 1);
        @(posedge clk); #1;
        check("clamp_a_wren_count", 32'(a_cnt0), 32);
        check("clamp_a_max", 32'(amax0), 31);
        check("clamp_byte0", 32'(a_mem0[0]), 'h61);
        check("clamp_byte31", 32'(a_mem0[31]), 'h61);

        // Reset asserted in WR_SJ, then a clean rerun
        for (int n = 0; n < 14; n++) ct_mem0[n] = 8'(atk_str[n]) ^ ks[n];
        do_prep();
        start0 = 1'b1; msg_len0 = 6'd14;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 0;
        while (!s_wren0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wr_sj_reached", 32'(s_wren0), 1);
        check("wr_sj_cycle", 32'(cyc), 4);
        reset = 1'b1;
        #1;
        check("rst_mid_s_wren", 32'(s_wren0), 0);
        check("rst_mid_busy", 32'(busy0), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_prep();
        run(1'b0, 6'd14, 1'b0, cyc);
        check("rerun_cycles", 32'(cyc), 86);
        check("rerun_success", 32'(success0), 1);
        @(posedge clk); #1;
        check("rerun_byte0", 32'(a_mem0[0]), 32'(atk_str[0]));
        check("rerun_byte13", 32'(a_mem0[13]), 32'(atk_str[13]));
        check("rerun_a_wren_count", 32'(a_cnt0), 14);

        // DROP_N=3 instance uses keystream bytes 3 onward
        for (int n = 0; n < 14; n++) ct_mem1[n] = 8'(atk_str[n]) ^ ks[n + 3];
        do_prep();
        run(1'b1, 6'd14, 1'b0, cyc);
        check("drop_cycles", 32'(cyc), 104);
        check("drop_success", 32'(success1), 1);
        check("drop_fail_index", 32'(fail_index1), 0);
        @(posedge clk); #1;
        for (int n = 0; n < 14; n++) check($sformatf("drop_byte%0d", n), 32'(a_mem1[n]), 32'(atk_str[n]));
        check("drop_a_wren_count", 32'(a_cnt1), 14);
        check("drop_s_wren_count", 32'(s_cnt1), 34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
